zrle_decoder: RTL and testbench
===============================

ZRLE_DECODER -- requirements
Module: zrle_decoder

Interface
REQ-001 Parameters SHALL come from ebpc_pkg, one per line:
- DATA_W, 8, input word width.
- LOG_MAX_ZRLE_LEN, 4, run-length field width L.
- MAX_ZRLE_LEN, 2**L, longest zero run per symbol.
- LEN_W, 16, width of frame bit count.

REQ-002 Ports SHALL be, one per line:
- clk_i  in  1  clock; one clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start frame; len_i sampled when accepted.
- len_i  in  LEN_W  number of decoded bits in frame.
- data_i  in  DATA_W  encoded word, MSB first.
- vld_i  in  1  data_i valid.
- rdy_o  out  1  word accepted when vld_i&&rdy_o.
- is_one_o  out  1  decoded bit.
- last_o  out  1  final bit of frame.
- vld_o  out  1  decoded bit valid.
- rdy_i  in  1  bit transferred when vld_o&&rdy_i.
- idle_o  out  1  no frame in progress.
- err_o  out  1  sticky: zero run overran frame length.

Function
REQ-003 Symbols SHALL be: '1' -> one 1-bit; '0' plus L-bit field f -> f+1 zero bits (1..MAX_ZRLE_LEN).
REQ-004 Symbols SHALL be parsed MSB-first from a 2*DATA_W-bit left-aligned buffer with fill counter fill (0..2*DATA_W).
REQ-005 States SHALL be IDLE, DECODE, ZEROS.
REQ-006 In IDLE: idle_o=1 and rdy_o=0.
- start_i with len_i!=0 SHALL latch rem=len_i, clear err_o, and go to DECODE.
- start_i with len_i==0 SHALL be ignored.
- start_i outside IDLE SHALL be ignored.
REQ-007 In DECODE/ZEROS: rdy_o=(fill_q<=DATA_W). An accepted word SHALL append at bit position fill after the same cycle's consumption.
REQ-008 In DECODE, vld_o SHALL be 1 iff:
- buffer MSB is 1 and fill>=1, with is_one_o=1; or
- buffer MSB is 0 and fill>=1+L, with is_one_o=0.
REQ-009 On a DECODE transfer:
- '1' symbol: consume 1 bit.
- zero symbol: consume 1+L bits, emit the first zero, and if f>0 go to ZEROS with run=f.
REQ-010 In ZEROS: vld_o=1 and is_one_o=0 regardless of fill. Each transfer decrements run; run reaching 0 returns to DECODE.
REQ-011 Every output transfer SHALL decrement rem. last_o=(rem==1).
- The transfer with last_o SHALL go to IDLE and clear buffer, fill, and run.
- Trailing padding bits SHALL be discarded.
REQ-012 If a zero run still has zeros pending when rem reaches 1, the frame SHALL end at last_o and err_o SHALL set. err_o stays set until the next accepted start_i.
REQ-013 Latency: a word accepted in cycle t SHALL allow vld_o in cycle t+1 at the earliest. Outputs SHALL be derived from registered state only.
REQ-014 Throughput SHALL be one decoded bit per cycle while rdy_i=1 and input keeps fill sufficient.
REQ-015 While vld_o=1 and rdy_i=0, is_one_o and last_o SHALL hold stable, and no state change other than word acceptance SHALL occur.
REQ-016 Input consumption and output transfer in the same cycle SHALL both take effect. fill SHALL never exceed 2*DATA_W.
REQ-017 DATA_W>=1+L SHALL hold; it is checked by an elaboration assertion.

Reset
REQ-018 Reset assertion SHALL force, asynchronously and from any state including mid-run:
- state=IDLE;
- buffer=0, fill=0, run=0, rem=0;
- err_o=0, vld_o=0, rdy_o=0, last_o=0, is_one_o=0, idle_o=1.
REQ-019 After reset release, the first start_i SHALL be accepted in the first clock edge.

Verification
REQ-020 Basic: start len=6, word 0xC5 -> bits 1,1,0,0,0,1 on 6 consecutive cycles; last_o on the 6th; then idle_o=1.
REQ-021 Max run and split symbol:
- len=16, word 0x78 -> 16 zeros, err_o=0.
- len=17, words 0x78,0x00 -> 17 zeros, last_o on the 17th.
REQ-022 Back-pressure: during REQ-020, rdy_i=0 for 3 cycles at bit 4 -> vld_o=1, is_one_o=0 held; the sequence is unchanged afterwards.
REQ-023 Throughput: len=16, words 0xFF,0xFF with vld_i always 1 -> 16 ones on consecutive cycles; last_o on the 16th.
REQ-024 Overrun: len=3, word 0x78 -> 3 zeros, last_o on the 3rd, err_o=1 until the next start_i.
REQ-025 Reset mid-ZEROS: assert rst_ni during REQ-021 run -> all outputs at reset values immediately; new frame from REQ-020 then decodes correctly.

Source files
------------

// File: rtl/ebpc_pkg.sv
// ebpc_pkg -- shared parameters for the encoded bit-plane compression blocks.
//   DATA_W           : encoded input word width
//   LOG_MAX_ZRLE_LEN : run-length field width L
//   MAX_ZRLE_LEN     : longest zero run one symbol can describe
//   LEN_W            : width of the per-frame decoded bit count
package ebpc_pkg;
  localparam int DATA_W           = 8;
  localparam int LOG_MAX_ZRLE_LEN = 4;
  localparam int MAX_ZRLE_LEN     = 2 ** LOG_MAX_ZRLE_LEN;
  localparam int LEN_W            = 16;
endpackage

// File: rtl/zrle_decoder.sv
// zrle_decoder -- zero run-length decoder, one decoded bit per cycle.
//
// Symbols, read MSB first from a left-aligned 2*DATA_W-bit buffer:
//   '1'          -> a single 1 bit
//   '0' + L bits -> f+1 zero bits (1..MAX_ZRLE_LEN)
// A frame carries len_i decoded bits; anything left in the buffer after the
// last bit is padding and is dropped.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i, len_i        start a frame of len_i decoded bits (IDLE only)
//   data_i, vld_i, rdy_o  encoded word input handshake
//   is_one_o, last_o,
//   vld_o, rdy_i          decoded bit output handshake
//   idle_o                no frame in progress
//   err_o                 sticky: a zero run was cut short by the frame end
module zrle_decoder
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic              is_one_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic              err_o
);

  localparam int L      = LOG_MAX_ZRLE_LEN;
  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  localparam logic [FILL_W-1:0] ONE_LEN  = FILL_W'(1);
  localparam logic [FILL_W-1:0] ZERO_LEN = FILL_W'(1 + L);
  localparam logic [FILL_W-1:0] WORD_LEN = FILL_W'(DATA_W);

  // A zero symbol must fit in the half of the buffer that is guaranteed to
  // be refilled, otherwise the decoder could starve with rdy_o low.
  if (DATA_W < 1 + L) begin : g_width_check
    $error("zrle_decoder: DATA_W must be at least 1 + LOG_MAX_ZRLE_LEN");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ZEROS
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [L-1:0]       run_q, run_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;

  logic               msb;
  logic [L-1:0]       field;
  logic               transfer;
  logic               accept;
  logic [FILL_W-1:0]  consume;
  logic [BUF_W-1:0]   buf_shift;
  logic [FILL_W-1:0]  fill_shift;

  assign msb   = buf_q[BUF_W-1];
  assign field = buf_q[BUF_W-2 -: L];

  // Outputs depend on registered state only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    vld_o = 1'b0;
    unique case (state_q)
      ST_DECODE: vld_o = msb ? (fill_q >= ONE_LEN) : (fill_q >= ZERO_LEN);
      ST_ZEROS:  vld_o = 1'b1;
      default:   vld_o = 1'b0;
    endcase
  end

  assign is_one_o = (state_q == ST_DECODE) && msb;
  assign last_o   = (state_q != ST_IDLE) && (rem_q == LEN_W'(1));
  assign rdy_o    = (state_q != ST_IDLE) && (fill_q <= WORD_LEN);
  assign idle_o   = (state_q == ST_IDLE);
  assign err_o    = err_q;

  assign transfer = vld_o && rdy_i;
  assign accept   = vld_i && rdy_o;

  // Bits leaving the buffer this cycle; only DECODE transfers consume.
  always_comb begin
    consume = '0;
    if (state_q == ST_DECODE && transfer) begin
      consume = msb ? ONE_LEN : ZERO_LEN;
    end
  end

  assign buf_shift  = buf_q << consume;
  assign fill_shift = fill_q - consume;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    run_d   = run_q;
    rem_d   = rem_q;
    err_d   = err_q;

    // New word lands right behind whatever survives this cycle's consumption.
    // rdy_o guarantees fill_shift <= DATA_W, so the buffer never overflows.
    if (accept) begin
      buf_d  = buf_shift | ({data_i, {DATA_W{1'b0}}} >> fill_shift);
      fill_d = fill_shift + WORD_LEN;
    end else begin
      buf_d  = buf_shift;
      fill_d = fill_shift;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d = ST_DECODE;
          rem_d   = len_i;
          err_d   = 1'b0;
        end
      end
      ST_DECODE: begin
        if (transfer && !msb && (field != '0)) begin
          state_d = ST_ZEROS;
          run_d   = field;
        end
      end
      ST_ZEROS: begin
        if (transfer) begin
          run_d = run_q - L'(1);
          if (run_q == L'(1)) begin
            state_d = ST_DECODE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (transfer) begin
      rem_d = rem_q - LEN_W'(1);
      if (last_o) begin
        // Frame ends here: drop padding and any zeros still owed.
        state_d = ST_IDLE;
        buf_d   = '0;
        fill_d  = '0;
        run_d   = '0;
        if ((state_q == ST_DECODE && !msb && field != '0) ||
            (state_q == ST_ZEROS && run_q > L'(1))) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      run_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_zrle_decoder.sv
// tb_zrle_decoder -- directed self-checking bench for zrle_decoder.
// Inputs are driven and outputs sampled on the falling edge; the DUT
// updates on the rising edge.
module tb_zrle_decoder;
  import ebpc_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  len_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              vld_i = 1'b0;
  logic              rdy_o;
  logic              is_one_o;
  logic              last_o;
  logic              vld_o;
  logic              rdy_i = 1'b1;
  logic              idle_o;
  logic              err_o;

  zrle_decoder dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .len_i    (len_i),
    .data_i   (data_i),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .is_one_o (is_one_o),
    .last_o   (last_o),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i),
    .idle_o   (idle_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] word_q[$];
  bit                got_one[$];
  bit                got_last[$];
  int                got_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [LEN_W-1:0] len);
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk_i);
    start_i = 1'b0;
    len_i   = '0;
  endtask

  // Feeds word_q and records output transfers until last_o or max_bits.
  // rdy_i drops for stall_n cycles once stall_at bits have been taken.
  task automatic collect(input int max_bits, input int stall_at, input int stall_n);
    int  stalls = 0;
    bit  done   = 1'b0;
    bit  saw_last = 1'b0;
    got_one.delete();
    got_last.delete();
    got_cyc.delete();
    for (int c = 0; c < 300 && !done; c++) begin
      if (got_one.size() == stall_at && stalls < stall_n) begin
        rdy_i = 1'b0;
        stalls++;
        check("bp_vld", vld_o, 1);
        check("bp_one", is_one_o, 0);
        check("bp_last", last_o, 0);
      end else begin
        rdy_i = 1'b1;
      end
      if (word_q.size() > 0) begin
        vld_i  = 1'b1;
        data_i = word_q[0];
      end else begin
        vld_i  = 1'b0;
        data_i = '0;
      end
      if (vld_i && rdy_o) void'(word_q.pop_front());
      if (vld_o && rdy_i) begin
        got_one.push_back(is_one_o);
        got_last.push_back(last_o);
        got_cyc.push_back(cyc);
        if (last_o) saw_last = 1'b1;
        if (last_o || got_one.size() == max_bits) done = 1'b1;
      end
      if (!done || saw_last) @(negedge clk_i);
    end
    if (!done) check("timeout", 0, 1);
    if (saw_last) begin
      vld_i  = 1'b0;
      data_i = '0;
      rdy_i  = 1'b1;
      word_q.delete();
    end
  endtask

  // exp_bits bit i is the i-th expected decoded bit.
  task automatic verify(input string tag, input int n_exp, input logic [31:0] exp_bits, input bit consec);
    int n = got_one.size();
    int gaps = 0;
    check({tag, "_count"}, n, n_exp);
    for (int i = 0; i < n && i < n_exp; i++) begin
      check($sformatf("%s_bit%0d", tag, i), got_one[i], exp_bits[i]);
      check($sformatf("%s_last%0d", tag, i), got_last[i], (i == n_exp - 1) ? 1 : 0);
      if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    end
    if (consec) check({tag, "_gaps"}, gaps, 0);
    check({tag, "_idle"}, idle_o, 1);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_idle", idle_o, 1);
    check("rst_vld", vld_o, 0);
    check("rst_rdy", rdy_o, 0);
    check("rst_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic: 0xC5 -> 1,1,0,0,0,1
    start_frame(16'd6);
    word_q.push_back(8'hC5);
    collect(100, -1, 0);
    verify("basic", 6, 32'h23, 1'b1);

    // Zero-length start is ignored
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = 16'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    check("len0_idle", idle_o, 1);
    check("len0_rdy", rdy_o, 0);

    // Max run: 16 zeros in one symbol
    start_frame(16'd16);
    word_q.push_back(8'h78);
    collect(100, -1, 0);
    verify("maxrun", 16, 32'h0, 1'b1);
    check("maxrun_err", err_o, 0);

    // Split symbol across two words: 16 + 1 zeros
    start_frame(16'd17);
    word_q.push_back(8'h78);
    word_q.push_back(8'h00);
    collect(100, -1, 0);
    verify("split", 17, 32'h0, 1'b1);
    check("split_err", err_o, 0);

    // Back-pressure at bit 4 for three cycles
    start_frame(16'd6);
    word_q.push_back(8'hC5);
    collect(100, 3, 3);
    verify("bp", 6, 32'h23, 1'b0);

    // Throughput: 16 ones on consecutive cycles
    start_frame(16'd16);
    word_q.push_back(8'hFF);
    word_q.push_back(8'hFF);
    collect(100, -1, 0);
    verify("thru", 16, 32'hFFFF, 1'b1);

    // Overrun: frame ends inside a zero run
    start_frame(16'd3);
    word_q.push_back(8'h78);
    collect(100, -1, 0);
    verify("ovr", 3, 32'h0, 1'b1);
    check("ovr_err", err_o, 1);
    repeat (2) @(negedge clk_i);
    check("ovr_err_hold", err_o, 1);
    start_frame(16'd1);
    check("ovr_err_clr", err_o, 0);
    word_q.push_back(8'h80);
    collect(100, -1, 0);
    verify("one", 1, 32'h1, 1'b1);

    // Reset in the middle of a zero run
    start_frame(16'd17);
    word_q.push_back(8'h78);
    word_q.push_back(8'h00);
    collect(5, -1, 0);
    check("mid_vld", vld_o, 1);
    check("mid_one", is_one_o, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_vld", vld_o, 0);
    check("arst_idle", idle_o, 1);
    check("arst_rdy", rdy_o, 0);
    check("arst_last", last_o, 0);
    check("arst_one", is_one_o, 0);
    check("arst_err", err_o, 0);
    word_q.delete();
    vld_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_frame(16'd6);
    word_q.push_back(8'hC5);
    collect(100, -1, 0);
    verify("post_rst", 6, 32'h23, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
